// File: rtl/stage_ex_pkg.sv
// Shared CPU definitions: ALU op codes, multiplier FSM states
// and the EX/ME pipeline bundle.
package stage_ex_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_LUI = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_SRA = 4'd8,
    ALU_SLT = 4'd9,
    ALU_MUL = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  localparam logic [4:0] MUL_LAST = 5'd31;

  typedef struct packed {
    logic        valid;
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic [4:0]  rn;
    logic [31:0] alu;
    logic [31:0] b;
  } ex_me_t;

endpackage

// File: rtl/stage_ex_mul.sv
// Iterative radix-2 shift-add multiplier, low 32 bits of a*b.
// IDLE -> BUSY (32 steps) -> DONE (one cycle) -> IDLE.
module mul_iter
  import stage_ex_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] p
);

  mul_state_e  state;
  mul_state_e  state_n;
  logic [4:0]  count;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] acc;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = BUSY;
      BUSY:    if (count == MUL_LAST) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (clear) state_n = IDLE;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (state == IDLE && start) begin
      count  <= '0;
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (state == BUSY) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 5'd1;
    end
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);
  assign p    = acc;

endmodule

// File: rtl/stage_ex.sv
// Execute stage: single-cycle ALU, iterative MUL with stall,
// and the EX/ME pipeline register.
module stage_ex
  import stage_ex_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        valid_de,
  input  logic [3:0]  aluc_de,
  input  logic [31:0] a_de,
  input  logic [31:0] b_de,
  input  logic [31:0] imm_de,
  input  logic        aluimm_de,
  input  logic        wreg_de,
  input  logic        m2reg_de,
  input  logic        wmem_de,
  input  logic [4:0]  rn_de,
  input  logic        flush_ex,
  output logic        stall_ex,
  output logic [31:0] alu_me,
  output logic [31:0] b_me,
  output logic        valid_me,
  output logic        wreg_me,
  output logic        m2reg_me,
  output logic        wmem_me,
  output logic [4:0]  rn_me
);

  logic [31:0] opb;
  logic [4:0]  shamt;
  logic [31:0] res;
  logic [31:0] prod;
  logic        mul_req;
  logic        mul_start;
  logic        mul_busy;
  logic        mul_done;
  logic        bubble;
  ex_me_t      q;

  assign opb   = aluimm_de ? imm_de : b_de;
  assign shamt = a_de[4:0];

  // stall covers the issue cycle plus all BUSY cycles, never DONE
  assign mul_req   = valid_de & (aluc_de == ALU_MUL) & ~flush_ex;
  assign mul_start = mul_req & ~mul_busy & ~mul_done;
  assign stall_ex  = resetn & (mul_start | (mul_req & mul_busy));

  mul_iter u_mul (
    .clock  (clock),
    .resetn (resetn),
    .clear  (flush_ex),
    .start  (mul_start),
    .a      (a_de),
    .b      (opb),
    .busy   (mul_busy),
    .done   (mul_done),
    .p      (prod)
  );

  always_comb begin
    res = '0;
    unique case (aluc_de)
      ALU_ADD: res = a_de + opb;
      ALU_SUB: res = a_de - opb;
      ALU_AND: res = a_de & opb;
      ALU_OR:  res = a_de | opb;
      ALU_XOR: res = a_de ^ opb;
      ALU_LUI: res = {opb[15:0], 16'h0000};
      ALU_SLL: res = opb << shamt;
      ALU_SRL: res = opb >> shamt;
      ALU_SRA: res = $signed(opb) >>> shamt;
      ALU_SLT: res = {31'b0, $signed(a_de) < $signed(opb)};
      ALU_MUL: res = prod;
      default: res = '0;
    endcase
  end

  assign bubble = flush_ex | stall_ex | ~valid_de;

  // bubbles clear the controls but keep the data fields
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      q <= '0;
    end else if (bubble) begin
      q.valid <= 1'b0;
      q.wreg  <= 1'b0;
      q.m2reg <= 1'b0;
      q.wmem  <= 1'b0;
    end else begin
      q.valid <= 1'b1;
      q.wreg  <= wreg_de;
      q.m2reg <= m2reg_de;
      q.wmem  <= wmem_de;
      q.rn    <= rn_de;
      q.alu   <= res;
      q.b     <= b_de;
    end
  end

  assign valid_me = q.valid;
  assign wreg_me  = q.wreg;
  assign m2reg_me = q.m2reg;
  assign wmem_me  = q.wmem;
  assign rn_me    = q.rn;
  assign alu_me   = q.alu;
  assign b_me     = q.b;

endmodule
